ram_mmio_uart: RTL and testbench

//  Responder on the core's data-RAM bus (ram_ce/ram_we/ram_addr/ram_sel/ram_data).

---
 rtl/ram_mmio_uart.sv | 193 +++++++++++++++++++
 tb/tb_ram_mmio_uart.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ram_mmio_uart.sv
// Data-RAM bus responder: byte-writable data RAM plus a memory-mapped 8N1 UART
// transmitter (TXDATA/STATUS/COUNT) fed from a circular TX FIFO.
module ram_mmio_uart #(
    parameter int unsigned RAM_ADDR_W   = 10,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ce,
    input  logic        ram_we,
    input  logic [31:0] ram_addr,
    input  logic [3:0]  ram_sel,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        uart_tx
);

    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TMR_W   = $clog2(CLKS_PER_BIT);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [31:0]           mem [2**RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0] word_idx;
    logic                  is_mmio;
    logic [3:0]            mmio_off;
    logic                  bus_wr;
    logic                  bus_rd;
    logic                  unused_addr;

    logic [7:0]            fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW:0]      fifo_cnt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  push_ok;
    logic                  pop;
    logic                  ovf;
    logic                  ovf_clr;

    tx_state_t             state;
    tx_state_t             state_n;
    logic [TMR_W-1:0]      tmr;
    logic [TMR_W-1:0]      tmr_n;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_idx_n;
    logic [7:0]            shreg;
    logic [7:0]            shreg_n;
    logic                  tx_bit;
    logic                  tx_busy;
    logic                  tx_q;

    assign word_idx    = ram_addr[RAM_ADDR_W+1:2];
    assign is_mmio     = (ram_addr[31:28] == 4'h1);
    assign mmio_off    = ram_addr[3:0];
    assign bus_wr      = ram_ce & ram_we;
    assign bus_rd      = ram_ce & ~ram_we;
    assign unused_addr = ^ram_addr;

    assign push       = bus_wr & is_mmio & ram_sel[0] & (mmio_off == 4'h0);
    assign ovf_clr    = bus_wr & is_mmio & ram_sel[0] & (mmio_off == 4'h4) & ram_data_i[3];
    assign fifo_full  = (fifo_cnt == CNT_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    // A full FIFO still accepts a push when the transmitter pops in the same cycle.
    assign push_ok    = push & (~fifo_full | pop);
    assign tx_busy    = (state != IDLE);
    assign uart_tx    = tx_q;

    always_ff @(posedge clk) begin
        if (bus_wr && !is_mmio) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ram_sel[i]) mem[word_idx][i*8 +: 8] <= ram_data_i[i*8 +: 8];
            end
        end
    end

    always_comb begin
        ram_data_o = '0;
        if (bus_rd) begin
            if (is_mmio) begin
                case (mmio_off)
                    4'h4:    ram_data_o = {28'b0, ovf, tx_busy, fifo_empty, fifo_full};
                    4'h8:    ram_data_o = 32'(fifo_cnt);
                    default: ram_data_o = '0;
                endcase
            end else begin
                ram_data_o = mem[word_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= ram_data_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
            else if (!push_ok && pop) fifo_cnt <= fifo_cnt - CNT_ONE;
            if (push && !push_ok) ovf <= 1'b1;
            else if (ovf_clr)     ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tmr     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx_q    <= tx_bit;
        end
    end

    // The line level follows the current state, so uart_tx lags the state by one cycle.
    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        pop       = 1'b0;
        tx_bit    = 1'b1;
        case (state)
            IDLE: begin
                tmr_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                tx_bit = 1'b0;
                if (tmr == TMR_LAST) begin
                    tmr_n     = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    tmr_n = tmr + TMR_ONE;
                end
            end
            DATA: begin
                tx_bit = shreg[0];
                if (tmr == TMR_LAST) begin
                    tmr_n   = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end else begin
                    tmr_n = tmr + TMR_ONE;
                end
            end
            STOP: begin
                tx_bit = 1'b1;
                if (tmr == TMR_LAST) begin
                    tmr_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_n = fifo_mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    tmr_n = tmr + TMR_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_mmio_uart.sv
// Directed bench for ram_mmio_uart: RAM lanes, MMIO registers and cycle-exact UART line checks.
module tb_ram_mmio_uart;

    localparam int CPB = 16;
    localparam logic [31:0] A_TX  = 32'h1000_0000;
    localparam logic [31:0] A_ST  = 32'h1000_0004;
    localparam logic [31:0] A_CNT = 32'h1000_0008;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_ce = 1'b0;
    logic        ram_we = 1'b0;
    logic [31:0] ram_addr = '0;
    logic [3:0]  ram_sel = '0;
    logic [31:0] ram_data_i = '0;
    logic [31:0] ram_data_o;
    logic        uart_tx;

    int tests = 0;
    int fails = 0;
    int c = 0;
    byte_q_t q;

    ram_mmio_uart #(.RAM_ADDR_W(10), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_sel(ram_sel), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    // Expected line level at cycle cc for back-to-back 8N1 frames starting at cycle st.
    function automatic logic exp_stream(input int cc, input int st, input byte_q_t bq);
        int rel, f, r;
        logic [7:0] b;
        rel = cc - st;
        if (rel < 0) return 1'b1;
        f = rel / (10 * CPB);
        r = rel % (10 * CPB);
        if (f >= bq.size()) return 1'b1;
        b = bq[f];
        if (r < CPB) return 1'b0;
        if (r < 9 * CPB) return b[(r - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        c++;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ram_ce = 1'b1; ram_we = 1'b1; ram_addr = a; ram_data_i = d; ram_sel = s;
        tick();
        ram_ce = 1'b0; ram_we = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ram_ce = 1'b1; ram_we = 1'b0; ram_addr = a; ram_sel = 4'h0;
        #1;
        check(tag, ram_data_o, exp);
        ram_ce = 1'b0;
    endtask

    task automatic chk_tx(input string tag, input logic exp);
        check($sformatf("%s c=%0d", tag, c), 32'(uart_tx), 32'(exp));
    endtask

    initial begin
        // 1: reset
        tick(); tick();
        rst = 1'b0;
        #1;
        chk_tx("reset_tx", 1'b1);
        chk_rd("reset_status", A_ST, 32'h2);
        chk_rd("reset_count", A_CNT, 32'h0);

        // 2: RAM byte lanes and decode corners
        wr(32'h0000_0040, 32'h1122_3344, 4'hF);
        wr(32'h0000_0040, 32'hAABB_CCDD, 4'h2);
        chk_rd("ram_lanes", 32'h0000_0040, 32'h1122_CC44);
        ram_ce = 1'b1; ram_we = 1'b1; ram_addr = 32'h0000_0040; ram_sel = 4'h0; ram_data_i = '1;
        #1;
        check("rdata_during_write", ram_data_o, 32'h0);
        tick();
        ram_ce = 1'b0; ram_we = 1'b0;
        #1;
        check("rdata_ce_low", ram_data_o, 32'h0);
        chk_rd("ram_sel0_write_noop", 32'h0000_0040, 32'h1122_CC44);
        wr(32'h0000_0044, 32'hDEAD_BEEF, 4'hF);
        chk_rd("ram_other_word", 32'h0000_0044, 32'hDEAD_BEEF);
        chk_rd("ram_word40_kept", 32'h0000_0040, 32'h1122_CC44);
        chk_rd("mmio_unmapped", 32'h1000_000C, 32'h0);
        chk_rd("txdata_reads_0", A_TX, 32'h0);
        wr(A_TX, 32'h77, 4'hE);
        chk_rd("tx_sel0_low_count", A_CNT, 32'h0);
        chk_rd("tx_sel0_low_status", A_ST, 32'h2);

        // 3: single byte 0x55, cycle-exact frame and busy window
        q = '{8'h55};
        c = -1;
        wr(A_TX, 32'h55, 4'h1);
        chk_rd("s3_status_queued", A_ST, 32'h0);
        chk_rd("s3_count_queued", A_CNT, 32'h1);
        while (c < 170) begin
            tick();
            chk_tx("s3_tx", exp_stream(c, 2, q));
            chk_rd($sformatf("s3_status c=%0d", c), A_ST, (c >= 1 && c <= 160) ? 32'h6 : 32'h2);
        end

        // 4: overflow with 10 back-to-back writes
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        c = -1;
        for (int i = 1; i <= 10; i++) wr(A_TX, 32'(i), 4'h1);
        chk_rd("s4_count_full", A_CNT, 32'h8);
        chk_rd("s4_status_ovf", A_ST, 32'hD);
        wr(A_ST, 32'h0, 4'h1);
        chk_rd("s4_status_noclr", A_ST, 32'hD);
        wr(A_ST, 32'h8, 4'h1);
        chk_rd("s4_status_clr", A_ST, 32'h5);
        while (c < 1470) begin
            tick();
            chk_tx("s4_tx", exp_stream(c, 2, q));
        end
        chk_rd("s4_status_end", A_ST, 32'h2);
        chk_rd("s4_count_end", A_CNT, 32'h0);

        // 5: back-to-back frames
        q = '{8'hA5, 8'h3C};
        c = -1;
        wr(A_TX, 32'hA5, 4'h1);
        wr(A_TX, 32'h3C, 4'h1);
        chk_rd("s5_count", A_CNT, 32'h1);
        while (c < 340) begin
            tick();
            chk_tx("s5_tx", exp_stream(c, 2, q));
            if (c == 161) chk_rd("s5_status_2nd", A_ST, 32'h6);
            if (c == 321) chk_rd("s5_status_idle", A_ST, 32'h2);
        end

        // 6: reset during DATA bit 3
        q = '{8'hF0, 8'h0F};
        c = -1;
        wr(A_TX, 32'hF0, 4'h1);
        wr(A_TX, 32'h0F, 4'h1);
        while (c < 70) tick();
        chk_tx("s6_bit3_before_rst", exp_stream(c, 2, q));
        chk_rd("s6_count_before_rst", A_CNT, 32'h1);
        rst = 1'b1;
        tick();
        #1;
        chk_tx("s6_tx_after_rst", 1'b1);
        chk_rd("s6_count_after_rst", A_CNT, 32'h0);
        chk_rd("s6_status_after_rst", A_ST, 32'h2);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            chk_tx("s6_tx_abandoned", 1'b1);
        end
        chk_rd("s6_ram_not_reset", 32'h0000_0040, 32'h1122_CC44);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
